// File: rtl/fc_act_writeback.sv
// fc_act_writeback
// Downstream stage of the fully-connected engine. It consumes the output-node
// stream (psum_i / valid_i / last_i).
//   - Hidden layers: each node goes through ReLU and is written to the ifmap
//     buffer at consecutive addresses starting at WR_BASE.
//   - Final layer (nth_fully_i == LAST_LAYER at start_i): nothing is written.
//     A signed argmax is computed instead, and the winning index appears on
//     class_o.
//   - layer_done_o pulses for one cycle when the layer completes.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           one-cycle pulse that arms/restarts a layer
//   nth_fully_i       layer index, sampled at start_i
//   psum_i            signed output-node value
//   valid_i, last_i   beat qualifier, final-node marker
//   ifmap_wren_o      ifmap write enable (registered)
//   ifmap_wrptr_o     ifmap write address (held while idle)
//   ifmap_wdata_o     ifmap write data (held while idle)
//   node_cnt_o        nodes accepted in the current or last layer
//   layer_done_o      one-cycle completion pulse
//   class_o           argmax index (final layer)
//   class_valid_o     class_o valid, held until next start_i
//   overflow_o        sticky: more than MAX_NODES beats seen
//
// state | meaning
// IDLE  | waiting for start_i; beats are ignored
// RUN   | accepting beats until valid_i && last_i
module fc_act_writeback #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int WR_BASE    = 0,
  parameter int MAX_NODES  = 84,
  parameter int LAST_LAYER = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        nth_fully_i,
  input  logic [DATA_W-1:0] psum_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ifmap_wren_o,
  output logic [ADDR_W-1:0] ifmap_wrptr_o,
  output logic [DATA_W-1:0] ifmap_wdata_o,
  output logic [6:0]        node_cnt_o,
  output logic              layer_done_o,
  output logic [6:0]        class_o,
  output logic              class_valid_o,
  output logic              overflow_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic signed [DATA_W-1:0] MAX_INIT  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [6:0]               CNT_LIMIT = 7'(MAX_NODES);
  localparam logic [6:0]               CNT_SAT   = 7'd127;

  state_t                    state;
  logic                      mode_final;
  logic signed [DATA_W-1:0]  max_val;
  logic [6:0]                best_idx;

  logic at_limit;
  logic take;
  logic beat_gt;

  assign at_limit = (node_cnt_o == CNT_LIMIT);
  // A beat is taken only in RUN, when start_i is not pre-empting it and the
  // node budget is not exhausted.
  assign take     = (state == RUN) && valid_i && !start_i && !at_limit;
  assign beat_gt  = ($signed(psum_i) > max_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_final    <= 1'b0;
      max_val       <= MAX_INIT;
      best_idx      <= '0;
      ifmap_wren_o  <= 1'b0;
      ifmap_wrptr_o <= '0;
      ifmap_wdata_o <= '0;
      node_cnt_o    <= '0;
      layer_done_o  <= 1'b0;
      class_o       <= '0;
      class_valid_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      ifmap_wren_o <= 1'b0;
      layer_done_o <= 1'b0;

      if (start_i) begin
        // Restart wins over any beat in the same cycle. A write registered
        // on the previous edge is already on the port and is not affected.
        state         <= RUN;
        mode_final    <= (nth_fully_i == 2'(LAST_LAYER));
        node_cnt_o    <= '0;
        class_valid_o <= 1'b0;
        overflow_o    <= 1'b0;
        max_val       <= MAX_INIT;
        best_idx      <= '0;
        class_o       <= '0;
      end else if (state == RUN && valid_i) begin
        if (at_limit) begin
          overflow_o <= 1'b1;
        end else begin
          if (node_cnt_o != CNT_SAT)
            node_cnt_o <= node_cnt_o + 7'd1;
          if (!mode_final) begin
            ifmap_wren_o  <= 1'b1;
            ifmap_wrptr_o <= ADDR_W'(WR_BASE) + ADDR_W'(node_cnt_o);
            ifmap_wdata_o <= psum_i[DATA_W-1] ? '0 : psum_i;
          end else if (beat_gt) begin
            max_val  <= psum_i;
            best_idx <= node_cnt_o;
          end
        end

        if (last_i) begin
          state        <= IDLE;
          layer_done_o <= 1'b1;
          if (mode_final) begin
            class_valid_o <= 1'b1;
            // The last beat can itself be the new maximum. In that case its
            // index is forwarded here, because best_idx only updates on this
            // same edge.
            class_o       <= (take && beat_gt) ? node_cnt_o : best_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_act_writeback.sv
module tb_fc_act_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] nth;
  logic [7:0] psum;
  logic       valid;
  logic       last;
  logic       wren;
  logic [9:0] wrptr;
  logic [7:0] wdata;
  logic [6:0] cnt;
  logic       done;
  logic [6:0] cls;
  logic       cv;
  logic       ovf;

  always #5 clk = ~clk;

  fc_act_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .nth_fully_i  (nth),
    .psum_i       (psum),
    .valid_i      (valid),
    .last_i       (last),
    .ifmap_wren_o (wren),
    .ifmap_wrptr_o(wrptr),
    .ifmap_wdata_o(wdata),
    .node_cnt_o   (cnt),
    .layer_done_o (done),
    .class_o      (cls),
    .class_valid_o(cv),
    .overflow_o   (ovf)
  );

  typedef struct {
    logic       start;
    logic [1:0] nth;
    logic [7:0] psum;
    logic       valid;
    logic       last;
    logic       wren;
    logic [9:0] ptr;
    logic [7:0] wd;
    logic [6:0] cnt;
    logic       done;
    logic [6:0] cls;
    logic       cv;
    logic       ovf;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_n   = 0;
  int done_n = 0;
  int wr_addr [256];
  int wr_data [256];
  vec_t vt [28];

  function automatic vec_t mk(input int st, input int nt, input int ps, input int va,
                              input int la, input int we, input int pt, input int wd,
                              input int ct, input int dn, input int cl, input int cvv,
                              input int ov);
    vec_t v;
    v.start = (st != 0);
    v.nth   = 2'(nt);
    v.psum  = 8'(ps);
    v.valid = (va != 0);
    v.last  = (la != 0);
    v.wren  = (we != 0);
    v.ptr   = 10'(pt);
    v.wd    = 8'(wd);
    v.cnt   = 7'(ct);
    v.done  = (dn != 0);
    v.cls   = 7'(cl);
    v.cv    = (cvv != 0);
    v.ovf   = (ov != 0);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and sample just after the
  // rising edge that captures them. Writes and done pulses are logged.
  task automatic step(input int st, input int nt, input int ps, input int va, input int la);
    @(negedge clk);
    start = (st != 0);
    nth   = 2'(nt);
    psum  = 8'(ps);
    valid = (va != 0);
    last  = (la != 0);
    @(posedge clk);
    #1;
    if (wren) begin
      if (wr_n < 256) begin
        wr_addr[wr_n] = int'(wrptr);
        wr_data[wr_n] = int'(wdata);
      end
      wr_n++;
    end
    if (done) done_n++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wren"},  int'(wren),  0);
    chk({tag, " wrptr"}, int'(wrptr), 0);
    chk({tag, " wdata"}, int'(wdata), 0);
    chk({tag, " cnt"},   int'(cnt),   0);
    chk({tag, " done"},  int'(done),  0);
    chk({tag, " class"}, int'(cls),   0);
    chk({tag, " cv"},    int'(cv),    0);
    chk({tag, " ovf"},   int'(ovf),   0);
  endtask

  initial begin
    int bad;
    int gaps;

    //           st nt  ps  va la | we pt  wd  ct dn cl cv ov
    vt[0]  = mk(1, 0,    0, 0, 0,   0, 0,   0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0,    5, 1, 0,   1, 0,   5, 1, 0, 0, 0, 0);
    vt[2]  = mk(0, 0,   -3, 1, 0,   1, 1,   0, 2, 0, 0, 0, 0);
    vt[3]  = mk(0, 0,  127, 1, 0,   1, 2, 127, 3, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, -128, 1, 0,   1, 3,   0, 4, 0, 0, 0, 0);
    vt[5]  = mk(0, 0,    0, 1, 1,   1, 4,   0, 5, 1, 0, 0, 0);
    vt[6]  = mk(0, 0,    0, 0, 0,   0, 4,   0, 5, 0, 0, 0, 0);
    vt[7]  = mk(1, 2,    0, 0, 0,   0, 4,   0, 0, 0, 0, 0, 0);
    vt[8]  = mk(0, 2,  -10, 1, 0,   0, 4,   0, 1, 0, 0, 0, 0);
    vt[9]  = mk(0, 2,   40, 1, 0,   0, 4,   0, 2, 0, 0, 0, 0);
    vt[10] = mk(0, 2,   40, 1, 0,   0, 4,   0, 3, 0, 0, 0, 0);
    vt[11] = mk(0, 2, -128, 1, 0,   0, 4,   0, 4, 0, 0, 0, 0);
    vt[12] = mk(0, 2,   39, 1, 0,   0, 4,   0, 5, 0, 0, 0, 0);
    vt[13] = mk(0, 2,    0, 1, 0,   0, 4,   0, 6, 0, 0, 0, 0);
    vt[14] = mk(0, 2,   -5, 1, 0,   0, 4,   0, 7, 0, 0, 0, 0);
    vt[15] = mk(0, 2,   12, 1, 0,   0, 4,   0, 8, 0, 0, 0, 0);
    vt[16] = mk(0, 2,   40, 1, 0,   0, 4,   0, 9, 0, 0, 0, 0);
    vt[17] = mk(0, 2,   -1, 1, 1,   0, 4,   0, 10, 1, 1, 1, 0);
    vt[18] = mk(0, 2,    0, 0, 0,   0, 4,   0, 10, 0, 1, 1, 0);
    vt[19] = mk(0, 2,  100, 1, 1,   0, 4,   0, 10, 0, 1, 1, 0);
    vt[20] = mk(1, 2,    0, 0, 0,   0, 4,   0, 0, 0, 0, 0, 0);
    vt[21] = mk(0, 2, -128, 1, 0,   0, 4,   0, 1, 0, 0, 0, 0);
    vt[22] = mk(0, 2, -128, 1, 1,   0, 4,   0, 2, 1, 0, 1, 0);
    vt[23] = mk(1, 0,    9, 1, 0,   0, 4,   0, 0, 0, 0, 0, 0);
    vt[24] = mk(0, 0,    7, 1, 0,   1, 0,   7, 1, 0, 0, 0, 0);
    vt[25] = mk(1, 1,    0, 0, 0,   0, 0,   7, 0, 0, 0, 0, 0);
    vt[26] = mk(0, 1,   -1, 1, 1,   1, 0,   0, 1, 1, 0, 0, 0);
    vt[27] = mk(0, 1,    0, 0, 0,   0, 0,   0, 1, 0, 0, 0, 0);

    rst_n = 1'b0;
    start = 1'b0;
    nth   = '0;
    psum  = '0;
    valid = 1'b0;
    last  = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed per-cycle table
    for (int i = 0; i < 28; i++) begin
      step(int'(vt[i].start), int'(vt[i].nth), int'(vt[i].psum),
           int'(vt[i].valid), int'(vt[i].last));
      chk($sformatf("v%0d wren", i),  int'(wren),  int'(vt[i].wren));
      chk($sformatf("v%0d wrptr", i), int'(wrptr), int'(vt[i].ptr));
      chk($sformatf("v%0d wdata", i), int'(wdata), int'(vt[i].wd));
      chk($sformatf("v%0d cnt", i),   int'(cnt),   int'(vt[i].cnt));
      chk($sformatf("v%0d done", i),  int'(done),  int'(vt[i].done));
      chk($sformatf("v%0d class", i), int'(cls),   int'(vt[i].cls));
      chk($sformatf("v%0d cv", i),    int'(cv),    int'(vt[i].cv));
      chk($sformatf("v%0d ovf", i),   int'(ovf),   int'(vt[i].ovf));
    end

    // Idle noise, then 84 beats with random gaps
    wr_n = 0;
    done_n = 0;
    step(0, 0, 33, 1, 0);
    step(0, 0, -4, 1, 1);
    step(0, 0, 50, 1, 0);
    chk("noise writes", wr_n, 0);
    chk("noise done", done_n, 0);
    chk("noise cnt", int'(cnt), 1);
    step(1, 0, 0, 0, 0);
    wr_n = 0;
    for (int i = 0; i < 84; i++) begin
      gaps = int'($urandom_range(0, 2));
      repeat (gaps) step(0, 0, 0, 0, 0);
      step(0, 0, i, 1, (i == 83) ? 1 : 0);
    end
    step(0, 0, 0, 0, 0);
    chk("gap writes", wr_n, 84);
    bad = 0;
    for (int i = 0; i < 84; i++)
      if (wr_addr[i] != i || wr_data[i] != i) bad++;
    chk("gap addr/data errors", bad, 0);
    chk("gap ovf", int'(ovf), 0);
    chk("gap done", done_n, 1);
    chk("gap cnt", int'(cnt), 84);

    // Overflow: 86 beats
    step(1, 0, 0, 0, 0);
    wr_n = 0;
    done_n = 0;
    for (int i = 0; i < 86; i++) begin
      step(0, 0, 1, 1, (i == 85) ? 1 : 0);
      if (i == 83) chk("ovf before beat 85", int'(ovf), 0);
      if (i == 84) chk("ovf at beat 85", int'(ovf), 1);
    end
    step(0, 0, 0, 0, 0);
    chk("ovf writes", wr_n, 84);
    chk("ovf last addr", wr_addr[83], 83);
    chk("ovf cnt", int'(cnt), 84);
    chk("ovf done", done_n, 1);
    chk("ovf sticky", int'(ovf), 1);

    // Restart mid-layer after 10 beats
    step(1, 0, 0, 0, 0);
    chk("restart clears ovf", int'(ovf), 0);
    for (int i = 0; i < 10; i++) step(0, 0, i + 1, 1, 0);
    chk("pre-restart cnt", int'(cnt), 10);
    step(1, 0, 0, 0, 0);
    chk("restart cnt", int'(cnt), 0);
    wr_n = 0;
    done_n = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 20 + i, 1, (i == 2) ? 1 : 0);
    chk("restart writes", wr_n, 3);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (wr_addr[i] != i || wr_data[i] != 20 + i) bad++;
    chk("restart addr/data errors", bad, 0);
    chk("restart cnt after", int'(cnt), 3);
    chk("restart done", done_n, 1);

    // Asynchronous reset while a write is on the port
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 9, 1, 0);
    chk("pre-reset wren", int'(wren), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    wr_n = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 5, 1, 0);
    chk("post-reset writes", wr_n, 0);
    chk("post-reset cnt", int'(cnt), 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 6, 1, 1);
    chk("post-reset wren", int'(wren), 1);
    chk("post-reset wrptr", int'(wrptr), 0);
    chk("post-reset wdata", int'(wdata), 6);
    chk("post-reset done", int'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_act_writeback.md
Name: fc_act_writeback

Overview:
- Downstream stage of the fully-connected engine; consumes its output-node stream (psum, valid, last).
- Hidden layers: applies ReLU to each node and writes it into the ifmap buffer write port at consecutive addresses, so the next FC layer can start.
- Final layer: skips ReLU and writeback and computes a signed argmax to produce the classification result.
- Issues a one-cycle layer-done pulse so the top-level sequencer can launch the next layer.

Parameters:
- DATA_W, 8, width of output-node data and ifmap write data.
- ADDR_W, 10, ifmap buffer write-pointer width.
- WR_BASE, 0, ifmap address of the first written node.
- MAX_NODES, 84, maximum legal output nodes per layer.
- LAST_LAYER, 2, nth_fully_i value identifying the final layer (argmax mode).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; arms block for a new layer.
- nth_fully_i  in  2  layer index; sampled at start_i.
- psum_i  in  DATA_W  output node value, signed two's complement.
- valid_i  in  1  psum_i valid this cycle.
- last_i  in  1  final node of layer; qualified by valid_i.
- ifmap_wren_o  out  1  ifmap buffer write enable.
- ifmap_wrptr_o  out  ADDR_W  ifmap buffer write address.
- ifmap_wdata_o  out  DATA_W  ifmap buffer write data.
- node_cnt_o  out  7  nodes accepted in current or last layer.
- layer_done_o  out  1  one-cycle pulse at layer completion.
- class_o  out  7  argmax node index (final layer only).
- class_valid_o  out  1  class_o valid; held until next start_i.
- overflow_o  out  1  sticky: more than MAX_NODES nodes received.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0; state IDLE; internal max register = -128.
- State machine:
  - IDLE -> RUN on start_i.
  - RUN -> IDLE on valid_i&&last_i.
  - start_i in RUN restarts the layer: counter cleared, mode resampled, stays RUN.
- On start_i, the block:
  - latches mode = (nth_fully_i==LAST_LAYER);
  - clears node_cnt_o, class_valid_o and overflow_o;
  - sets max register to -128 and class_o to 0.
- valid_i in IDLE: ignored, no write, no count.
- RUN, valid_i, hidden mode: registered write on the next cycle.
  - ifmap_wren_o=1.
  - ifmap_wrptr_o = WR_BASE + node_cnt (pre-increment value).
  - ifmap_wdata_o = psum_i[7] ? 0 : psum_i (ReLU).
  - Latency is exactly 1 cycle. Back-to-back valid_i gives back-to-back writes with no bubbles.
- RUN, valid_i, final mode:
  - no writes; ifmap_wren_o stays 0.
  - If signed psum_i > max, update max and record index = node_cnt.
  - Ties keep the lowest index (strict greater-than).
- node_cnt increments on every accepted valid_i, saturating at 127.
- Overflow: when node_cnt==MAX_NODES and valid_i arrives, the block:
  - sets overflow_o (sticky until next start_i);
  - suppresses the write and the argmax update;
  - does not increment the count;
  - still honours last_i.
- valid_i&&last_i at cycle t:
  - the final write (hidden mode) occurs at t+1;
  - layer_done_o=1 at t+1 for exactly one cycle;
  - final mode: class_o holds the final argmax and class_valid_o=1, both from t+1.
- Wrap: address arithmetic is modulo 2^ADDR_W. WR_BASE+MAX_NODES must not exceed the buffer depth; this is an integration constraint, not checked.
- Simultaneous start_i with valid_i in RUN: start_i wins; the data beat is dropped.
- Simultaneous start_i with a pending registered write from the previous cycle: the write completes.
- rst_n assertion mid-layer: immediate return to IDLE, all outputs 0, any pending write cancelled.
- ifmap_wrptr_o and ifmap_wdata_o hold their last value when ifmap_wren_o=0.

Test Plan:
- Hidden ReLU path: start_i, nth_fully_i=0; stream psum {5,-3,127,-128,0} with last_i on the 5th beat. Required:
  - writes at addr 0..4 with data {5,0,127,0,0}, each one cycle after its beat;
  - layer_done_o pulses once, coincident with the addr-4 write;
  - node_cnt_o=5.
- Final-layer argmax: start_i, nth_fully_i=2; psum {-10,40,40,-128,39,...} over 10 nodes with a max of 40 at indices 1 and 2. Required:
  - no ifmap_wren_o;
  - class_o=1 and class_valid_o=1 from the cycle after last_i, held until next start_i.
- Gapped stream plus IDLE noise: valid_i pulses before start_i, then 84 beats with random idle gaps. Required:
  - pre-start beats ignored;
  - exactly 84 writes at addresses 0..83;
  - overflow_o=0.
- Overflow: 86 beats, last_i on beat 86. Required:
  - 84 writes;
  - overflow_o=1 from beat 85;
  - node_cnt_o=84;
  - layer_done_o still pulses.
- Restart and reset: start_i mid-layer after 10 beats; then 3 beats. Required:
  - writes restart at addr 0.
  - Separately, rst_n low mid-stream: all outputs 0 immediately; no further writes until the next start_i.
